seg_display_mux: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment display driver; successor to the fixed 4-digit nibble/anode scanner.

---
 rtl/seg_display_mux.sv | 160 ++++++++++++++++
 tb/tb_seg_display_mux.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - N-digit multiplexed 7-segment display scanner with tear-free shadowing
module seg_display_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 400000,
  parameter int BLANK_CYCLES   = 4000,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       data,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lz_blank,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          slot_strobe
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_CYCLES);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]        BLANK_END = (CNT_W + 1)'(BLANK_CYCLES);
  // "Off" levels double as XOR masks that turn active-high patterns into pin levels.
  localparam logic [6:0]            SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]        cnt;
  logic                    load_pending;
  logic [4*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_lz;

  logic                    slot_end;
  logic                    frame_end;
  logic                    load_now;
  logic                    in_blank;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [3:0]              cur_nib;
  logic                    cur_en;
  logic                    cur_dp;
  logic                    cur_dark;
  logic                    visible;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    seg_decode = 7'b0111111;
      4'h1:    seg_decode = 7'b0000110;
      4'h2:    seg_decode = 7'b1011011;
      4'h3:    seg_decode = 7'b1001111;
      4'h4:    seg_decode = 7'b1100110;
      4'h5:    seg_decode = 7'b1101101;
      4'h6:    seg_decode = 7'b1111101;
      4'h7:    seg_decode = 7'b0000111;
      4'h8:    seg_decode = 7'b1111111;
      4'h9:    seg_decode = 7'b1101111;
      4'hA:    seg_decode = 7'b1110111;
      4'hB:    seg_decode = 7'b1111100;
      4'hC:    seg_decode = 7'b0111001;
      4'hD:    seg_decode = 7'b1011110;
      4'hE:    seg_decode = 7'b1111001;
      default: seg_decode = 7'b1110001;
    endcase
  endfunction

  assign slot_end    = (cnt == CNT_LAST);
  assign frame_end   = slot_end && (digit_idx == IDX_LAST);
  assign load_now    = load_pending || frame_end;
  assign slot_strobe = slot_end;
  assign in_blank    = (BLANK_CYCLES > 0) && ({1'b0, cnt} < BLANK_END);

  // Slot timer and digit pointer; the pointer wraps explicitly so odd digit counts stay in range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (slot_end) begin
      cnt       <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      cnt       <= cnt + 1'b1;
    end
  end

  // Shadow copy of all display inputs, refreshed only at frame boundaries so a frame never mixes two values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data      <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      sh_lz        <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (load_now) begin
        sh_data <= data;
        sh_dp   <= dp_in;
        sh_en   <= digit_en;
        sh_lz   <= lz_blank;
      end
    end
  end

  // Leading-zero mask: walk from the most significant digit down while every nibble seen so far is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_dark  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (sh_data[4*i +: 4] == 4'h0);
      lz_dark[i] = sh_lz && zero_run && (i != 0);
    end
  end

  // Pick out the shadowed attributes of the digit currently being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_en    = 1'b0;
    cur_dp    = 1'b0;
    cur_dark  = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        cur_nib      = sh_data[4*i +: 4];
        cur_en       = sh_en[i];
        cur_dp       = sh_dp[i];
        cur_dark     = lz_dark[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  assign visible = !in_blank && cur_en && !cur_dark;

  // Registered pin drive; a dark digit turns every anode off so at most one anode is ever on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end else if (visible) begin
      seg <= seg_decode(cur_nib) ^ SEG_OFF;
      dp  <= cur_dp ^ DP_OFF;
      an  <= an_onehot ^ AN_OFF;
    end else begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      an  <= AN_OFF;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb/tb_seg_display_mux.sv - directed bench for seg_display_mux (4 digits, 8-cycle slots, 2-cycle blank)
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        slot_strobe;

  int n_checks = 0;
  int n_fail   = 0;

  seg_display_mux #(
    .NUM_DIGITS    (4),
    .REFRESH_CYCLES(8),
    .BLANK_CYCLES  (2),
    .AN_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .digit_idx  (digit_idx),
    .slot_strobe(slot_strobe)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Advance one clock and park on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    data = 16'h1234; dp_in = 4'h0; digit_en = 4'hF; lz_blank = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL rst_an: got %b expected 1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL rst_seg: got %b expected 1111111", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL rst_dp: got %b expected 1", dp); end
    n_checks++; if (slot_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe: got %b expected 0", slot_strobe); end
    n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL rst_idx: got %0d expected 0", digit_idx); end
    step();
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL rst_hold_an: got %b expected 1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL rst_hold_seg: got %b expected 1111111", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL rst_hold_dp: got %b expected 1", dp); end
  endtask

  task automatic test_scan();
    logic [6:0] tab [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [1:0] e_idx;
    int pos, d;
    tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    rst = 1'b0;
    n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL scan_start_idx: got %0d expected 0", digit_idx); end
    n_checks++; if (slot_strobe !== 1'b0) begin n_fail++; $display("FAIL scan_start_strobe: got %b expected 0", slot_strobe); end
    for (int j = 0; j < 64; j++) begin
      step();
      pos   = j % 8;
      d     = (j / 8) % 4;
      e_an  = (pos < 2) ? 4'hF : ~(4'b0001 << d);
      e_seg = (pos < 2) ? 7'h7F : tab[d];
      e_idx = 2'(((j + 1) / 8) % 4);
      n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL scan_an j=%0d: got %b expected %b", j, an, e_an); end
      n_checks++; if (seg !== e_seg) begin n_fail++; $display("FAIL scan_seg j=%0d: got %b expected %b", j, seg, e_seg); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL scan_dp j=%0d: got %b expected 1", j, dp); end
      n_checks++; if (slot_strobe !== (pos == 6)) begin n_fail++; $display("FAIL scan_strobe j=%0d: got %b expected %b", j, slot_strobe, (pos == 6)); end
      n_checks++; if (digit_idx !== e_idx) begin n_fail++; $display("FAIL scan_idx j=%0d: got %0d expected %0d", j, digit_idx, e_idx); end
    end
  endtask

  task automatic test_frame_hold();
    logic [6:0] tab [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int pos, d;
    tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    for (int j = 0; j < 64; j++) begin
      if (j == 10) data = 16'h8888;
      step();
      pos   = j % 8;
      d     = (j / 8) % 4;
      e_an  = (pos < 2) ? 4'hF : ~(4'b0001 << d);
      e_seg = (pos < 2) ? 7'h7F : ((j < 32) ? tab[d] : 7'b0000000);
      n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL hold_an j=%0d: got %b expected %b", j, an, e_an); end
      n_checks++; if (seg !== e_seg) begin n_fail++; $display("FAIL hold_seg j=%0d: got %b expected %b", j, seg, e_seg); end
    end
  endtask

  task automatic test_lz_blank();
    logic [6:0] tab [4];
    bit         vis [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int pos, d;
    tab = '{7'b1000000, 7'b1111000, 7'h7F, 7'h7F};
    vis = '{1'b1, 1'b1, 1'b0, 1'b0};
    data = 16'h0070; lz_blank = 1'b1; dp_in = 4'b0010; digit_en = 4'hF;
    for (int j = 0; j < 32; j++) step();
    for (int j = 0; j < 32; j++) begin
      step();
      pos   = j % 8;
      d     = j / 8;
      e_an  = (pos < 2 || !vis[d]) ? 4'hF : ~(4'b0001 << d);
      e_seg = (pos < 2 || !vis[d]) ? 7'h7F : tab[d];
      e_dp  = (pos >= 2 && d == 1) ? 1'b0 : 1'b1;
      n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL lz_an j=%0d: got %b expected %b", j, an, e_an); end
      n_checks++; if (seg !== e_seg) begin n_fail++; $display("FAIL lz_seg j=%0d: got %b expected %b", j, seg, e_seg); end
      n_checks++; if (dp !== e_dp) begin n_fail++; $display("FAIL lz_dp j=%0d: got %b expected %b", j, dp, e_dp); end
    end
  endtask

  task automatic test_enable_dp();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int pos, d;
    data = 16'h0000; lz_blank = 1'b1; dp_in = 4'b0100; digit_en = 4'b1011;
    for (int j = 0; j < 32; j++) step();
    for (int j = 0; j < 32; j++) begin
      step();
      pos   = j % 8;
      d     = j / 8;
      e_an  = (pos >= 2 && d == 0) ? 4'b1110 : 4'hF;
      e_seg = (pos >= 2 && d == 0) ? 7'b1000000 : 7'h7F;
      n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL en_an j=%0d: got %b expected %b", j, an, e_an); end
      n_checks++; if (seg !== e_seg) begin n_fail++; $display("FAIL en_seg j=%0d: got %b expected %b", j, seg, e_seg); end
      n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL en_dp j=%0d: got %b expected 1", j, dp); end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [6:0] tab [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [1:0] e_idx;
    int pos, d;
    tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    data = 16'h1234; lz_blank = 1'b0; dp_in = 4'h0; digit_en = 4'hF;
    for (int j = 0; j < 32; j++) step();
    for (int j = 0; j < 20; j++) step();
    n_checks++; if (an !== 4'b1011) begin n_fail++; $display("FAIL mid_pre_an: got %b expected 1011", an); end
    n_checks++; if (seg !== 7'b0100100) begin n_fail++; $display("FAIL mid_pre_seg: got %b expected 0100100", seg); end
    n_checks++; if (digit_idx !== 2'd2) begin n_fail++; $display("FAIL mid_pre_idx: got %0d expected 2", digit_idx); end
    rst = 1'b1;
    #1;
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL mid_rst_an: got %b expected 1111", an); end
    n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL mid_rst_seg: got %b expected 1111111", seg); end
    n_checks++; if (dp !== 1'b1) begin n_fail++; $display("FAIL mid_rst_dp: got %b expected 1", dp); end
    n_checks++; if (digit_idx !== 2'd0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d expected 0", digit_idx); end
    step();
    n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL mid_rst_hold_an: got %b expected 1111", an); end
    rst = 1'b0;
    n_checks++; if (slot_strobe !== 1'b0) begin n_fail++; $display("FAIL mid_rel_strobe: got %b expected 0", slot_strobe); end
    for (int j = 0; j < 32; j++) begin
      step();
      pos   = j % 8;
      d     = j / 8;
      e_an  = (pos < 2) ? 4'hF : ~(4'b0001 << d);
      e_seg = (pos < 2) ? 7'h7F : tab[d];
      e_idx = 2'(((j + 1) / 8) % 4);
      n_checks++; if (an !== e_an) begin n_fail++; $display("FAIL mid_an j=%0d: got %b expected %b", j, an, e_an); end
      n_checks++; if (seg !== e_seg) begin n_fail++; $display("FAIL mid_seg j=%0d: got %b expected %b", j, seg, e_seg); end
      n_checks++; if (digit_idx !== e_idx) begin n_fail++; $display("FAIL mid_idx j=%0d: got %0d expected %0d", j, digit_idx, e_idx); end
    end
  endtask

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_frame_hold();
    test_lz_blank();
    test_enable_dp();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
